// File: rtl/cap_scan_pkg.sv
// Purpose: shared FSM state type and default sizes for the capacitive touch scanner.
// Latency: none (types and constants only).
// Backpressure: none.
package cap_scan_pkg;

  localparam int NUM_CH_DEFAULT  = 9;
  localparam int COUNT_W_DEFAULT = 16;
  // Each channel's reading occupies a fixed 32-bit slot on the readings bus.
  localparam int SLOT_W          = 32;

  typedef enum logic [1:0] {
    IDLE,
    DISCHARGE,
    CHARGE,
    PUBLISH
  } scan_state_t;

endpackage

// File: rtl/cap_scan_channel.sv
// Purpose: one sense channel -- pad synchronizer, latched flag and captured charge count.
// Latency: pad edge reaches the capture logic two clocks after it is sampled.
// Backpressure: none; capture is one-shot per scan and cleared during DISCHARGE.
module cap_scan_channel
  import cap_scan_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sense_in,
  input  logic               clear,
  input  logic               charge,
  input  logic               timeout,
  input  logic [COUNT_W-1:0] counter,
  output logic               done,
  output logic [COUNT_W-1:0] count
);

  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               latched_q, latched_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               capture;

  // Synchronize the pad and capture the counter on the first high sample (or at timeout).
  always_comb begin
    sync1_d   = sense_in;
    sync2_d   = sync1_q;
    latched_d = latched_q;
    count_d   = count_q;
    // A timeout capture stores the counter, which equals the timeout value in that cycle.
    capture   = charge & ~latched_q & (sync2_q | timeout);
    if (clear) begin
      latched_d = 1'b0;
      count_d   = '0;
    end else if (capture) begin
      latched_d = 1'b1;
      count_d   = counter;
    end
  end

  // Channel state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      latched_q <= 1'b0;
      count_q   <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      latched_q <= latched_d;
      count_q   <= count_d;
    end
  end

  // Done counts a channel that latches this cycle so the scan can exit without waiting a clock.
  assign done  = latched_q | sync2_q;
  assign count = count_q;

endmodule

// File: rtl/cap_touch_scanner.sv
// Purpose: multi-channel capacitive touch scanner (discharge, timed charge, publish); CAP_SCAN_FILTER_EN adds an IIR filter.
// Latency: DISCHARGE_CYCLES + charge time (at most TIMEOUT_CYCLES+1) + 1 publish cycle per scan.
// Backpressure: none; readings/touched hold between publishes, scan_done pulses once per scan.
module cap_touch_scanner
  import cap_scan_pkg::*;
#(
  parameter int NUM_CH           = NUM_CH_DEFAULT,
  parameter int COUNT_W          = COUNT_W_DEFAULT,
  parameter int DISCHARGE_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES   = 65535
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        sense_in,
  output logic                     drive_out,
  input  logic [COUNT_W-1:0]       threshold,
  output logic [SLOT_W*NUM_CH-1:0] readings,
  output logic [NUM_CH-1:0]        touched,
  output logic                     scan_done
);

  localparam int                 DIS_W       = (DISCHARGE_CYCLES > 1) ? $clog2(DISCHARGE_CYCLES) : 1;
  localparam logic [DIS_W-1:0]   DIS_LAST    = DIS_W'(DISCHARGE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] TIMEOUT_VAL = COUNT_W'(TIMEOUT_CYCLES);

  scan_state_t                     state_q, state_d;
  logic [DIS_W-1:0]                dis_q, dis_d;
  logic [COUNT_W-1:0]              counter_q, counter_d;
  logic [NUM_CH-1:0][COUNT_W-1:0]  pub_q, pub_d;
  logic [NUM_CH-1:0]               touched_q, touched_d;
  logic                            scan_done_q, scan_done_d;
  logic [NUM_CH-1:0][COUNT_W-1:0]  raw;
  logic [NUM_CH-1:0]               ch_done;
  logic                            in_charge;
  logic                            in_discharge;
  logic                            timeout;
  logic                            all_done;

`ifdef CAP_SCAN_FILTER_EN
  logic loaded_q, loaded_d;

  // prev + ((raw - prev) >>> 2) in signed COUNT_W+1 bits; the result always lies between prev and raw.
  function automatic logic [COUNT_W-1:0] filt(input logic [COUNT_W-1:0] prev,
                                              input logic [COUNT_W-1:0] cur);
    logic signed [COUNT_W:0] acc;
    acc = $signed({1'b0, cur}) - $signed({1'b0, prev});
    acc = acc >>> 2;
    acc = $signed({1'b0, prev}) + acc;
    return acc[COUNT_W-1:0];
  endfunction
`endif

  assign in_charge    = (state_q == CHARGE);
  assign in_discharge = (state_q == DISCHARGE);
  assign timeout      = in_charge && (counter_q == TIMEOUT_VAL);
  assign all_done     = &ch_done;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    cap_scan_channel #(
      .COUNT_W (COUNT_W)
    ) u_ch (
      .clock    (clock),
      .reset    (reset),
      .sense_in (sense_in[i]),
      .clear    (in_discharge),
      .charge   (in_charge),
      .timeout  (timeout),
      .counter  (counter_q),
      .done     (ch_done[i]),
      .count    (raw[i])
    );
  end

  // Scan sequencing: discharge hold, charge timing with early exit or timeout, single publish cycle.
  always_comb begin
    state_d   = state_q;
    dis_d     = dis_q;
    counter_d = counter_q;
    case (state_q)
      IDLE: begin
        dis_d     = '0;
        counter_d = '0;
        if (enable) state_d = DISCHARGE;
      end
      DISCHARGE: begin
        counter_d = '0;
        if (dis_q == DIS_LAST) begin
          dis_d   = '0;
          state_d = CHARGE;
        end else begin
          dis_d = dis_q + 1'b1;
        end
      end
      CHARGE: begin
        // The counter stops at the exit cycle, so it never passes TIMEOUT_VAL and cannot wrap.
        if (timeout || all_done) state_d = PUBLISH;
        else                     counter_d = counter_q + 1'b1;
      end
      PUBLISH: begin
        counter_d = '0;
        state_d   = enable ? DISCHARGE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Publish path: update readings and touch flags once per scan, threshold sampled now.
  always_comb begin
    pub_d       = pub_q;
    touched_d   = touched_q;
    scan_done_d = 1'b0;
`ifdef CAP_SCAN_FILTER_EN
    loaded_d    = loaded_q;
`endif
    if (state_q == PUBLISH) begin
      scan_done_d = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
`ifdef CAP_SCAN_FILTER_EN
        // First publish after reset seeds the filter with the raw count.
        pub_d[i] = loaded_q ? filt(pub_q[i], raw[i]) : raw[i];
`else
        pub_d[i] = raw[i];
`endif
        touched_d[i] = (pub_d[i] > threshold);
      end
`ifdef CAP_SCAN_FILTER_EN
      loaded_d = 1'b1;
`endif
    end
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      dis_q       <= '0;
      counter_q   <= '0;
      pub_q       <= '0;
      touched_q   <= '0;
      scan_done_q <= 1'b0;
`ifdef CAP_SCAN_FILTER_EN
      loaded_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      dis_q       <= dis_d;
      counter_q   <= counter_d;
      pub_q       <= pub_d;
      touched_q   <= touched_d;
      scan_done_q <= scan_done_d;
`ifdef CAP_SCAN_FILTER_EN
      loaded_q    <= loaded_d;
`endif
    end
  end

  // Zero-extend each published count into its 32-bit reading slot.
  always_comb begin
    readings = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      readings[i*SLOT_W +: SLOT_W] = SLOT_W'(pub_q[i]);
    end
  end

  assign drive_out = in_charge;
  assign touched   = touched_q;
  assign scan_done = scan_done_q;

endmodule

// File: doc/cap_touch_scanner.md
CAP_TOUCH_SCANNER -- requirements
Module: cap_touch_scanner

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- NUM_CH, 9: sensor channels.
- COUNT_W, 16: charge-counter width.
- DISCHARGE_CYCLES, 1000: drive-low hold per scan.
- TIMEOUT_CYCLES, 65535: charge limit; must be less than 2^COUNT_W.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clock, in, 1: the single clock; all flops on its rising edge.
- reset, in, 1: asynchronous, active-high.
- enable, in, 1: run continuous scans.
- sense_in, in, NUM_CH: raw pad inputs, asynchronous to clock.
- drive_out, out, 1: shared charge/discharge drive.
- threshold, in, COUNT_W: touch threshold.
- readings, out, 32*NUM_CH: channel i occupies bits [32i+31:32i], zero-extended count.
- touched, out, NUM_CH: per-channel touch flag.
- scan_done, out, 1: one-cycle pulse when readings update.

Function
REQ-003 Each sense_in bit SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-004 The FSM SHALL have states IDLE, DISCHARGE, CHARGE, PUBLISH.
REQ-005 IDLE: drive_out=0; go to DISCHARGE the cycle after enable=1 is sampled.
REQ-006 DISCHARGE: drive_out=0 for exactly DISCHARGE_CYCLES cycles, then CHARGE.
REQ-007 CHARGE: drive_out=1; the counter is 0 in the first CHARGE cycle and increments by 1 each cycle.
REQ-008 Each channel SHALL latch the counter value in the first CHARGE cycle its synchronized input is 1, and hold it for the rest of the scan.
REQ-009 Channel already high in the first CHARGE cycle: latched value 0.
REQ-010 All channels latched: go to PUBLISH on the next cycle (early exit).
REQ-011 Counter equals TIMEOUT_CYCLES: unlatched channels take TIMEOUT_CYCLES; go to PUBLISH. A channel latching in that same cycle keeps its own value, which equals TIMEOUT_CYCLES.
REQ-012 PUBLISH (one cycle):
- readings and touched registered, and scan_done=1.
- drive_out=0.
- Next state is DISCHARGE if enable=1, else IDLE.
REQ-013 touched[i] SHALL be 1 iff the published reading[i] is strictly greater than threshold, with threshold sampled in PUBLISH.
REQ-014 enable deasserted mid-scan: the current scan SHALL complete and publish, then go to IDLE.
REQ-015 readings and touched SHALL hold their values between PUBLISH cycles.
REQ-016 Counter arithmetic SHALL be unsigned COUNT_W bits and never wrap, because the timeout fires first.

Reset
REQ-017 On reset=1 (asynchronous): state=IDLE, drive_out=0, readings=0, touched=0, scan_done=0, counter=0, latches cleared, synchronizers cleared.
REQ-018 Reset asserted mid-scan SHALL abort the scan with no PUBLISH; operation resumes from IDLE after release.

Configuration
REQ-019 With macro CAP_SCAN_FILTER_EN defined, the published reading SHALL be prev + ((raw - prev) >>> 2), using signed (COUNT_W+1)-bit arithmetic.
REQ-020 With CAP_SCAN_FILTER_EN defined, the first PUBLISH after reset SHALL load raw directly.
REQ-021 With CAP_SCAN_FILTER_EN undefined, the published reading SHALL be the raw latched count, with no extra state.
REQ-022 touched SHALL always compare against the published (filtered or raw) value.

Structure
REQ-023 Package cap_scan_pkg SHALL hold:
- the FSM state enum;
- NUM_CH and COUNT_W defaults;
- the 32-bit reading-slot width constant.
REQ-024 Sub-module cap_scan_channel SHALL contain one channel's synchronizer, latch flag and captured count; it is instantiated NUM_CH times.

Verification
(All scenarios use DISCHARGE_CYCLES=4, TIMEOUT_CYCLES=50, threshold=20.)
REQ-025 Reset, then enable=1; sense_in[i] rises 10+i cycles after drive_out rises.
- Required: readings[i] = 12+i (2-cycle sync delay).
- Required: touched = 9'b0; one scan_done pulse.
REQ-026 sense_in[3] held 0, others rise at cycle 5.
- Required: reading[3] = 50, touched = 9'b000001000.
- Required: others read 7 with touched = 0.
REQ-027 sense_in all 1 throughout.
- Required: all readings = 0.
- Required: PUBLISH occurs one cycle after the first CHARGE cycle.
REQ-028 enable dropped during CHARGE.
- Required: that scan publishes, then drive_out stays 0 and no further scan_done.
REQ-029 reset pulsed mid-CHARGE.
- Required: outputs return to 0 immediately and no scan_done.
- Required: the next scan after release publishes normally.
REQ-030 CAP_SCAN_FILTER_EN defined, raw 40 then 0.
- Required: published readings 40 then 30.
